// File: rtl/conv_ifmap_loader.sv
// conv_ifmap_loader: streams one filter + ifmap tile from a single-port buffer
// into parallel FILTER_OUT / DATA_OUT arrays and holds the tile until it is consumed.
module conv_ifmap_loader #(
    parameter int unsigned INWIDTH = 16,
    parameter int unsigned FIL_S   = 3,
    parameter int unsigned DI_W    = 7,
    parameter int unsigned DI_H    = 7,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         fil_base,
    input  logic [ADDR_W-1:0]         dat_base,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_gnt,
    input  logic signed [INWIDTH-1:0] mem_rd_data,
    output logic signed [INWIDTH-1:0] FILTER_OUT [0:FIL_S-1][0:FIL_S-1],
    output logic signed [INWIDTH-1:0] DATA_OUT   [0:DI_H-1][0:DI_W-1],
    output logic                      tile_valid,
    input  logic                      consume,
    output logic                      busy
);

    localparam int unsigned NF     = FIL_S * FIL_S;
    localparam int unsigned ND     = DI_H * DI_W;
    localparam int unsigned NT     = NF + ND;
    localparam int unsigned CNT_W  = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned FIL_IW = (FIL_S > 1) ? $clog2(FIL_S) : 1;
    localparam int unsigned DR_W   = (DI_H > 1) ? $clog2(DI_H) : 1;
    localparam int unsigned DC_W   = (DI_W > 1) ? $clog2(DI_W) : 1;
    localparam int unsigned RC_A   = (FIL_IW > DR_W) ? FIL_IW : DR_W;
    localparam int unsigned RC_W   = (RC_A > DC_W) ? RC_A : DC_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FIL   = 3'd1;
    localparam logic [2:0] S_DAT   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]        state, state_d;
    logic [CNT_W-1:0]  iss, iss_d;
    logic [CNT_W-1:0]  rcv, rcv_d;
    logic              pend, pend_d;
    logic [RC_W-1:0]   rrow, rrow_d;
    logic [RC_W-1:0]   rcol, rcol_d;
    logic [ADDR_W-1:0] fil_base_q, fil_base_d;
    logic [ADDR_W-1:0] dat_base_q, dat_base_d;
    logic [ADDR_W-1:0] req_addr;
    logic              req_acc;
    logic              fil_ret;
    logic              last_ret;

    // Next-state, counter and next-request computation
    always_comb begin
        state_d    = state;
        iss_d      = iss;
        rcv_d      = rcv;
        pend_d     = 1'b0;
        rrow_d     = rrow;
        rcol_d     = rcol;
        fil_base_d = fil_base_q;
        dat_base_d = dat_base_q;
        req_addr   = mem_addr;

        req_acc  = mem_rd_en && mem_gnt;
        fil_ret  = (rcv < CNT_W'(NF));
        last_ret = pend && (rcv == CNT_W'(NT - 1));

        case (state)
            S_IDLE: begin
                if (start) begin
                    fil_base_d = fil_base;
                    dat_base_d = dat_base;
                    iss_d      = '0;
                    rcv_d      = '0;
                    rrow_d     = '0;
                    rcol_d     = '0;
                    state_d    = S_FIL;
                end
            end
            S_FIL: begin
                if (req_acc) begin
                    pend_d = 1'b1;
                    iss_d  = iss + CNT_W'(1);
                    if (iss == CNT_W'(NF - 1)) begin
                        state_d = S_DAT;
                    end
                end
            end
            S_DAT: begin
                if (req_acc) begin
                    pend_d = 1'b1;
                    if (iss == CNT_W'(NT - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        iss_d = iss + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (last_ret) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (consume) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Return side: step the destination row/column after each captured word;
        // the filter section wraps to (0,0) so the ifmap starts at its origin.
        if (pend && !last_ret) begin
            rcv_d = rcv + CNT_W'(1);
            if (fil_ret) begin
                if (rcol == RC_W'(FIL_S - 1)) begin
                    rcol_d = '0;
                    rrow_d = (rrow == RC_W'(FIL_S - 1)) ? '0 : rrow + RC_W'(1);
                end else begin
                    rcol_d = rcol + RC_W'(1);
                end
            end else begin
                if (rcol == RC_W'(DI_W - 1)) begin
                    rcol_d = '0;
                    rrow_d = rrow + RC_W'(1);
                end else begin
                    rcol_d = rcol + RC_W'(1);
                end
            end
        end

        // Address for the request presented next cycle; held while not requesting
        if (state_d == S_FIL) begin
            req_addr = fil_base_d + ADDR_W'(iss_d);
        end else if (state_d == S_DAT) begin
            req_addr = dat_base_d + ADDR_W'(iss_d) - ADDR_W'(NF);
        end
    end

    // State, counters and registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            iss        <= '0;
            rcv        <= '0;
            pend       <= 1'b0;
            rrow       <= '0;
            rcol       <= '0;
            fil_base_q <= '0;
            dat_base_q <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            tile_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            iss        <= iss_d;
            rcv        <= rcv_d;
            pend       <= pend_d;
            rrow       <= rrow_d;
            rcol       <= rcol_d;
            fil_base_q <= fil_base_d;
            dat_base_q <= dat_base_d;
            mem_rd_en  <= (state_d == S_FIL) || (state_d == S_DAT);
            mem_addr   <= req_addr;
            tile_valid <= (state_d == S_HOLD);
            busy       <= (state_d != S_IDLE);
        end
    end

    // Tile arrays: capture each returning word at its row-major slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < FIL_S; r++) begin
                for (int unsigned c = 0; c < FIL_S; c++) begin
                    FILTER_OUT[FIL_IW'(r)][FIL_IW'(c)] <= '0;
                end
            end
            for (int unsigned r = 0; r < DI_H; r++) begin
                for (int unsigned c = 0; c < DI_W; c++) begin
                    DATA_OUT[DR_W'(r)][DC_W'(c)] <= '0;
                end
            end
        end else if (pend) begin
            if (fil_ret) begin
                FILTER_OUT[FIL_IW'(rrow)][FIL_IW'(rcol)] <= mem_rd_data;
            end else begin
                DATA_OUT[DR_W'(rrow)][DC_W'(rcol)] <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_conv_ifmap_loader.sv
// Testbench for conv_ifmap_loader: memory model with 1-cycle read latency,
// tile contents predicted directly from the memory image and base addresses.
module tb_conv_ifmap_loader;

    localparam int INWIDTH = 16;
    localparam int FIL_S   = 3;
    localparam int DI_W    = 7;
    localparam int DI_H    = 7;
    localparam int ADDR_W  = 12;
    localparam int NF      = FIL_S * FIL_S;
    localparam int ND      = DI_H * DI_W;
    localparam int NT      = NF + ND;

    logic clk, rst, start, mem_rd_en, mem_gnt, tile_valid, consume, busy;
    logic [ADDR_W-1:0] fil_base, dat_base, mem_addr;
    logic signed [INWIDTH-1:0] mem_rd_data;
    logic signed [INWIDTH-1:0] filter_out [0:FIL_S-1][0:FIL_S-1];
    logic signed [INWIDTH-1:0] data_out   [0:DI_H-1][0:DI_W-1];
    logic signed [INWIDTH-1:0] mem [0:4095];
    logic [ADDR_W-1:0] req_q [$];
    int checks = 0;
    int errors = 0;

    conv_ifmap_loader #(
        .INWIDTH(INWIDTH), .FIL_S(FIL_S), .DI_W(DI_W), .DI_H(DI_H), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .fil_base(fil_base), .dat_base(dat_base),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rd_data(mem_rd_data), .FILTER_OUT(filter_out), .DATA_OUT(data_out),
        .tile_valid(tile_valid), .consume(consume), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: accepted request returns its word in the following cycle
    always @(posedge clk) begin
        if (mem_rd_en && mem_gnt) begin
            req_q.push_back(mem_addr);
            mem_rd_data <= mem[mem_addr];
        end else begin
            mem_rd_data <= 16'sh5A5A;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void fill_identity();
        for (int a = 0; a < 4096; a++) mem[a] = 16'(a);
    endfunction

    // Number of array words differing from the tile the buffer image predicts
    function automatic int tile_diffs(input logic [ADDR_W-1:0] fb, input logic [ADDR_W-1:0] db);
        int n = 0;
        for (int r = 0; r < FIL_S; r++)
            for (int c = 0; c < FIL_S; c++)
                if (filter_out[2'(r)][2'(c)] !== mem[12'(int'(fb) + r * FIL_S + c)]) n++;
        for (int r = 0; r < DI_H; r++)
            for (int c = 0; c < DI_W; c++)
                if (data_out[3'(r)][3'(c)] !== mem[12'(int'(db) + r * DI_W + c)]) n++;
        return n;
    endfunction

    function automatic int nonzero_words();
        int n = 0;
        for (int r = 0; r < FIL_S; r++)
            for (int c = 0; c < FIL_S; c++)
                if (filter_out[2'(r)][2'(c)] !== 16'sh0) n++;
        for (int r = 0; r < DI_H; r++)
            for (int c = 0; c < DI_W; c++)
                if (data_out[3'(r)][3'(c)] !== 16'sh0) n++;
        return n;
    endfunction

    // Requests seen that are not the expected stream address for their position
    function automatic int addr_diffs(input logic [ADDR_W-1:0] fb, input logic [ADDR_W-1:0] db);
        int n = 0;
        logic [ADDR_W-1:0] e;
        for (int k = 0; k < req_q.size(); k++) begin
            e = (k < NF) ? 12'(int'(fb) + k) : 12'(int'(db) + k - NF);
            if (req_q[k] !== e) n++;
        end
        return n;
    endfunction

    // Issue start at the current cycle and wait for tile_valid; lat is cycles from start edge
    task automatic run_tile(input logic [ADDR_W-1:0] fb, input logic [ADDR_W-1:0] db,
                            input bit rand_gnt, output int lat, output int gnt_low);
        int cyc;
        req_q.delete();
        gnt_low  = 0;
        fil_base = fb;
        dat_base = db;
        mem_gnt  = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!tile_valid && cyc < 2000) begin
            mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_rd_en && !mem_gnt) gnt_low++;
            @(posedge clk); #1;
            cyc++;
        end
        lat     = tile_valid ? cyc : -1;
        mem_gnt = 1'b1;
    endtask

    task automatic do_consume();
        consume = 1'b1;
        @(posedge clk); #1;
        consume = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_rd_en !== 1'b0 || busy !== 1'b0 || tile_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got rd_en=%b busy=%b valid=%b required 0 0 0", mem_rd_en, busy, tile_valid); end
        checks++; if (mem_addr !== 12'h000) begin
            errors++; $display("FAIL reset_addr: got %h required 000", mem_addr); end
        checks++; if (nonzero_words() !== 0) begin
            errors++; $display("FAIL reset_arrays: got %0d nonzero words required 0", nonzero_words()); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL idle_no_start: got busy=%b rd_en=%b required 0 0", busy, mem_rd_en); end
    endtask

    task automatic test_basic();
        int lat, gl;
        run_tile(12'h000, 12'h100, 1'b0, lat, gl);
        checks++; if (lat !== NT + 2) begin
            errors++; $display("FAIL basic_latency: got %0d required %0d", lat, NT + 2); end
        checks++; if (req_q.size() !== NT) begin
            errors++; $display("FAIL basic_req_count: got %0d required %0d", req_q.size(), NT); end
        checks++; if (addr_diffs(12'h000, 12'h100) !== 0) begin
            errors++; $display("FAIL basic_addr_seq: got %0d wrong addresses required 0", addr_diffs(12'h000, 12'h100)); end
        checks++; if (filter_out[1][2] !== 16'sd5) begin
            errors++; $display("FAIL basic_fil_1_2: got %h required 0005", filter_out[1][2]); end
        checks++; if (data_out[6][6] !== 16'sh0130) begin
            errors++; $display("FAIL basic_dat_6_6: got %h required 0130", data_out[6][6]); end
        checks++; if (tile_diffs(12'h000, 12'h100) !== 0) begin
            errors++; $display("FAIL basic_tile: got %0d wrong words required 0", tile_diffs(12'h000, 12'h100)); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (tile_valid !== 1'b1 || busy !== 1'b1 || mem_rd_en !== 1'b0 || req_q.size() !== NT) begin
            errors++; $display("FAIL basic_hold: got valid=%b busy=%b rd_en=%b reqs=%0d required 1 1 0 %0d",
                               tile_valid, busy, mem_rd_en, req_q.size(), NT); end
        do_consume();
        checks++; if (tile_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_consume: got valid=%b busy=%b required 0 0", tile_valid, busy); end
        checks++; if (tile_diffs(12'h000, 12'h100) !== 0) begin
            errors++; $display("FAIL basic_keep_after_consume: got %0d wrong words required 0", tile_diffs(12'h000, 12'h100)); end
    endtask

    task automatic test_random_gnt();
        int lat, gl;
        logic [ADDR_W-1:0] fb, db;
        for (int it = 0; it < 4; it++) begin
            fb = (it == 0) ? 12'h000 : 12'($urandom_range(0, 4000));
            db = (it == 0) ? 12'h100 : 12'($urandom_range(0, 4000));
            run_tile(fb, db, 1'b1, lat, gl);
            checks++; if (lat !== NT + 2 + gl) begin
                errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", it, lat, NT + 2 + gl); end
            checks++; if (req_q.size() !== NT || addr_diffs(fb, db) !== 0) begin
                errors++; $display("FAIL rand_addr_seq[%0d]: got %0d reqs %0d wrong required %0d reqs 0 wrong",
                                   it, req_q.size(), addr_diffs(fb, db), NT); end
            checks++; if (tile_diffs(fb, db) !== 0) begin
                errors++; $display("FAIL rand_tile[%0d]: got %0d wrong words required 0", it, tile_diffs(fb, db)); end
            do_consume();
        end
    endtask

    task automatic test_ignored_controls();
        int cyc, bad;
        req_q.delete();
        mem_gnt  = 1'b1;
        fil_base = 12'h040;
        dat_base = 12'h300;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        fil_base = 12'h800;
        dat_base = 12'h900;
        checks++; if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 12'h040) begin
            errors++; $display("FAIL ign_first_req: got busy=%b rd_en=%b addr=%h required 1 1 040", busy, mem_rd_en, mem_addr); end
        cyc = 1;
        while (!tile_valid && cyc < 2000) begin
            start   = (cyc == 3) || (cyc == NT + 1);
            consume = (cyc == 20);
            @(posedge clk); #1;
            cyc++;
        end
        start   = 1'b0;
        consume = 1'b0;
        checks++; if (cyc !== NT + 2 || tile_valid !== 1'b1) begin
            errors++; $display("FAIL ign_latency: got %0d required %0d", cyc, NT + 2); end
        checks++; if (req_q.size() !== NT || addr_diffs(12'h040, 12'h300) !== 0) begin
            errors++; $display("FAIL ign_addr_seq: got %0d reqs %0d wrong required %0d reqs 0 wrong",
                               req_q.size(), addr_diffs(12'h040, 12'h300), NT); end
        checks++; if (tile_diffs(12'h040, 12'h300) !== 0) begin
            errors++; $display("FAIL ign_tile: got %0d wrong words required 0", tile_diffs(12'h040, 12'h300)); end
        req_q.delete();
        start = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (tile_valid !== 1'b1 || mem_rd_en !== 1'b0) bad++;
        end
        checks++; if (bad !== 0 || req_q.size() !== 0) begin
            errors++; $display("FAIL ign_start_in_hold: got %0d bad cycles %0d reqs required 0 0", bad, req_q.size()); end
        do_consume();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || mem_rd_en !== 1'b0 || tile_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0 || req_q.size() !== 0) begin
            errors++; $display("FAIL ign_idle_after: got %0d bad cycles %0d reqs required 0 0", bad, req_q.size()); end
    endtask

    task automatic test_mid_reset();
        int cyc, lat, gl;
        req_q.delete();
        mem_gnt  = 1'b1;
        fil_base = 12'h000;
        dat_base = 12'h100;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (req_q.size() < 20 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (req_q.size() !== 20) begin
            errors++; $display("FAIL mrst_reach20: got %0d reqs required 20", req_q.size()); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (mem_rd_en !== 1'b0 || mem_addr !== 12'h000 || busy !== 1'b0 || tile_valid !== 1'b0) begin
            errors++; $display("FAIL mrst_outputs: got rd_en=%b addr=%h busy=%b valid=%b required 0 000 0 0",
                               mem_rd_en, mem_addr, busy, tile_valid); end
        checks++; if (nonzero_words() !== 0) begin
            errors++; $display("FAIL mrst_arrays: got %0d nonzero words required 0", nonzero_words()); end
        @(posedge clk); #1;
        checks++; if (nonzero_words() !== 0 || mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL mrst_inflight: got %0d nonzero words rd_en=%b required 0 0", nonzero_words(), mem_rd_en); end
        run_tile(12'h020, 12'h180, 1'b1, lat, gl);
        checks++; if (lat !== NT + 2 + gl) begin
            errors++; $display("FAIL mrst_restart_lat: got %0d required %0d", lat, NT + 2 + gl); end
        checks++; if (tile_diffs(12'h020, 12'h180) !== 0 || addr_diffs(12'h020, 12'h180) !== 0) begin
            errors++; $display("FAIL mrst_restart_tile: got %0d wrong words required 0", tile_diffs(12'h020, 12'h180)); end
        do_consume();
    endtask

    task automatic test_back_to_back();
        int lat, gl;
        run_tile(12'h010, 12'h100, 1'b0, lat, gl);
        checks++; if (lat !== NT + 2) begin
            errors++; $display("FAIL b2b_first_lat: got %0d required %0d", lat, NT + 2); end
        do_consume();
        checks++; if (tile_valid !== 1'b0 || tile_diffs(12'h010, 12'h100) !== 0) begin
            errors++; $display("FAIL b2b_hold_old: got valid=%b %0d wrong words required 0 0", tile_valid, tile_diffs(12'h010, 12'h100)); end
        run_tile(12'h030, 12'h200, 1'b0, lat, gl);
        checks++; if (lat !== NT + 2) begin
            errors++; $display("FAIL b2b_second_lat: got %0d required %0d", lat, NT + 2); end
        checks++; if (data_out[0][0] !== 16'sh0200) begin
            errors++; $display("FAIL b2b_dat_0_0: got %h required 0200", data_out[0][0]); end
        checks++; if (tile_diffs(12'h030, 12'h200) !== 0) begin
            errors++; $display("FAIL b2b_tile: got %0d wrong words required 0", tile_diffs(12'h030, 12'h200)); end
        do_consume();
    endtask

    task automatic test_signed();
        int lat, gl;
        for (int a = 12'h500; a < 12'h509; a++) mem[a] = 16'($urandom);
        for (int a = 12'h600; a < 12'h631; a++) mem[a] = 16'($urandom);
        mem[12'h500] = 16'sh8000;
        mem[12'h501] = 16'shFFFF;
        mem[12'h600] = 16'shFFFF;
        mem[12'h630] = 16'sh8000;
        run_tile(12'h500, 12'h600, 1'b1, lat, gl);
        checks++; if (filter_out[0][0] !== 16'sh8000 || filter_out[0][1] !== 16'shFFFF) begin
            errors++; $display("FAIL signed_fil: got %h %h required 8000 ffff", filter_out[0][0], filter_out[0][1]); end
        checks++; if (data_out[0][0] !== 16'shFFFF || data_out[6][6] !== 16'sh8000) begin
            errors++; $display("FAIL signed_dat: got %h %h required ffff 8000", data_out[0][0], data_out[6][6]); end
        checks++; if (tile_diffs(12'h500, 12'h600) !== 0) begin
            errors++; $display("FAIL signed_tile: got %0d wrong words required 0", tile_diffs(12'h500, 12'h600)); end
        do_consume();
        fill_identity();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        consume  = 1'b0;
        mem_gnt  = 1'b1;
        fil_base = '0;
        dat_base = '0;
        fill_identity();
        test_reset();
        test_basic();
        test_random_gnt();
        test_ignored_controls();
        test_mid_reset();
        test_back_to_back();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_ifmap_loader.md
# conv_ifmap_loader

Fetches one convolution tile from a single-port on-chip buffer and presents it in parallel to the conv PE array: a FIL_S×FIL_S filter followed by a DI_H×DI_W input feature map, both read as single words. It is the read-side counterpart of the array's output path. The block turns a serial memory stream into the parallel FILTER / DATA_IN arrays that the 3×5 row-stationary PE grid consumes. It holds the assembled tile stable until the array acknowledges it.

## Interface
- INWIDTH, 16, word width (signed fixed point, format not interpreted here)
- FIL_S, 3, filter side length
- DI_W, 7, ifmap width (columns)
- DI_H, 7, ifmap height (rows)
- ADDR_W, 12, buffer address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to load one tile; honoured only in IDLE
- fil_base  in  ADDR_W  filter base address; sampled when start is accepted
- dat_base  in  ADDR_W  ifmap base address; sampled when start is accepted
- mem_rd_en  out  1  read request
- mem_addr  out  ADDR_W  read address
- mem_gnt  in  1  request accepted this cycle when mem_rd_en && mem_gnt
- mem_rd_data  in  INWIDTH signed  read data, valid exactly 1 cycle after an accepted request
- FILTER_OUT  out  [0:FIL_S-1][0:FIL_S-1] × INWIDTH signed  assembled filter
- DATA_OUT  out  [0:DI_H-1][0:DI_W-1] × INWIDTH signed  assembled ifmap
- tile_valid  out  1  both arrays are complete and stable
- consume  in  1  array has taken the tile; honoured only while tile_valid
- busy  out  1  high in every state except IDLE

## Operation
- Stream layout:
  - NF = FIL_S² filter words, then ND = DI_H·DI_W ifmap words, for a total of NT = NF+ND (58 with the defaults).
  - Stream index k < NF reads address fil_base+k and is written to FILTER_OUT[k/FIL_S][k%FIL_S].
  - Stream index k ≥ NF reads address dat_base+(k−NF) and is written to DATA_OUT[(k−NF)/DI_W][(k−NF)%DI_W]. Both are row-major.
- Counters:
  - Issue counter iss (0..NT−1) advances on each accepted request.
  - Return counter rcv (0..NT−1) advances on each return.
  - An internal flag pend is set on acceptance and marks the return in the next cycle; rcv selects the destination register.
- FSM:
  - IDLE: on start, latch both bases, clear iss and rcv, go to FIL.
  - FIL: mem_rd_en=1, mem_addr=fil_base+iss. On the accepted request with iss=NF−1, go to DAT.
  - DAT: mem_rd_en=1, mem_addr=dat_base+(iss−NF). On the accepted request with iss=NT−1, go to DRAIN.
  - DRAIN: mem_rd_en=0. When the return with rcv=NT−1 is captured, go to HOLD.
  - HOLD: tile_valid=1. On consume, go to IDLE.
- mem_gnt low: mem_rd_en stays high, mem_addr is held, and iss does not advance. There are no gaps in the return pipeline beyond the gnt stalls.
- Arrays are overwritten word by word during a fetch. Contents are undefined for the consumer until tile_valid is high. Arrays keep their contents after consume; nothing clears them except rst.
- start outside IDLE is ignored, including while in HOLD.
- consume outside HOLD is ignored.
- Data is stored unmodified: no sign extension, rounding or arithmetic.

## Timing
- Reset values, applied on any rst cycle, including mid-fetch:
  - state IDLE
  - mem_rd_en=0, mem_addr=0
  - tile_valid=0, busy=0
  - all FILTER_OUT and DATA_OUT words = 0
  - iss, rcv and pend = 0
- A return in flight when rst is asserted is discarded: pend is cleared, so no array write occurs.
- With mem_gnt held at 1 and start sampled at edge T:
  - mem_rd_en is high in cycles T+1 .. T+NT (58 cycles).
  - The last return arrives in cycle T+NT+1.
  - tile_valid goes high in cycle T+NT+2 (T+60 with the defaults).
  - Start-to-valid latency is NT+2 cycles, plus one cycle for each gnt-low cycle while requesting.
- busy rises the cycle after start is accepted and falls the cycle after consume is accepted.
- tile_valid falls the cycle after consume is accepted.
- A new start is accepted no earlier than the cycle after tile_valid falls.
- There is exactly one memory request per word. There are never two outstanding requests, and never a request in DRAIN, HOLD or IDLE.

## Test plan
- Reset then load, mem_gnt=1, fil_base=0x000, dat_base=0x100, memory word at address a = a:
  - exactly 58 requests, to addresses 0..8 then 0x100..0x130
  - FILTER_OUT[1][2]=5, DATA_OUT[6][6]=0x130
  - tile_valid rises 60 cycles after start
- Random mem_gnt (50% duty) with the same image: identical final arrays, addresses never skip or repeat, and latency = 60 + number of gnt-low request cycles.
- start pulsed in FIL, DRAIN and HOLD: ignored, with no extra requests and no change in iss. consume pulsed in DAT: ignored.
- rst asserted in the cycle after the 20th accepted request:
  - next cycle: IDLE, all outputs 0, arrays zeroed
  - the in-flight return for address 0x10B is not written
  - a fresh start then completes normally.
- Back-to-back tiles:
  - consume in the first HOLD cycle, start in the next cycle with dat_base=0x200.
  - Arrays hold the first tile until overwritten; the second tile_valid shows the new data, e.g. DATA_OUT[0][0]=0x200.
- Signed data check: memory returns 0x8000 and 0xFFFF; the arrays hold the same bit patterns unchanged.
